// File: rtl/core_halt_ctrl.sv
// Per-core halt/resume controller: decodes halt command words, drives core_halt_o, waits for the core's ack.
// Latency: response 2..TIMEOUT_CYCLES+1 cycles after accept (1 cycle for a bad command).
// Backpressure: cmd_ready_o low outside IDLE (one command per 3 cycles at best); the response cannot be stalled.
module core_halt_ctrl #(
  parameter int                    NUM_CPUS       = 2,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [NUM_CPUS-1:0]   RESET_HALT     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_data_i,
  output logic [NUM_CPUS-1:0] core_halt_o,
  input  logic [NUM_CPUS-1:0] core_halted_i,
  output logic                rsp_valid_o,
  output logic [1:0]          rsp_status_o,
  output logic                busy_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADCMD  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

  state_t        state;
  logic [1:0]    core_q;
  logic          tgt_q;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          legal;
  logic          ack_bit;
  logic          accept;

  // Encoding 6/7 addresses core 0; every other pair addresses the next core up.
  always_comb begin
    idx   = (cmd_data_i[2:1] == 2'd3) ? 3'd0 : ({1'b0, cmd_data_i[2:1]} + 3'd1);
    legal = (cmd_data_i[31:3] == 29'd0) && (int'(idx) < NUM_CPUS);
  end

  always_comb begin
    ack_bit = 1'b0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (int'(core_q) == i) ack_bit = core_halted_i[i];
    end
  end

  assign cmd_ready_o = (state == IDLE) && rst_n;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      core_halt_o  <= RESET_HALT;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= ST_OK;
      busy_o       <= 1'b0;
      cnt          <= '0;
      core_q       <= 2'd0;
      tgt_q        <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              state        <= RESP;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= ST_BADCMD;
            end else begin
              for (int i = 0; i < NUM_CPUS; i++) begin
                if (int'(idx) == i) core_halt_o[i] <= ~cmd_data_i[0];
              end
              core_q <= idx[1:0];
              tgt_q  <= ~cmd_data_i[0];
              cnt    <= '0;
              busy_o <= 1'b1;
              state  <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (ack_bit == tgt_q) begin
            state        <= RESP;
            busy_o       <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= ST_OK;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state        <= RESP;
            busy_o       <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= ST_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_halt_ctrl.sv
// Directed bench for core_halt_ctrl: two cores, 8-cycle timeout, core 1 held halted out of reset.
module tb_core_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_data_i;
  logic [1:0]  core_halt_o;
  logic [1:0]  core_halted_i;
  logic        rsp_valid_o;
  logic [1:0]  rsp_status_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  core_halt_ctrl #(.NUM_CPUS(2), .TIMEOUT_CYCLES(8), .RESET_HALT(2'b10)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_data_i(cmd_data_i), .core_halt_o(core_halt_o), .core_halted_i(core_halted_i),
    .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (the caller has checked cmd_ready_o).
  task automatic send(input logic [31:0] d);
    cmd_valid_i = 1'b1;
    cmd_data_i  = d;
    tick();
    cmd_valid_i = 1'b0;
    cmd_data_i  = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_data_i = 32'h0; core_halted_i = 2'b10;
    tick(); tick();
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low got %b want 0", cmd_ready_o); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (core_halt_o !== 2'b10) begin n_bad++; $display("FAIL reset_halt got %b want 10", core_halt_o); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
    n_cmp++; if (rsp_status_o !== 2'b00) begin n_bad++; $display("FAIL reset_status got %b want 00", rsp_status_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
  endtask

  task automatic test_halt_core0();
    int busy_cnt = 0;
    send(32'h6);
    // cycle T+1
    n_cmp++; if (core_halt_o !== 2'b11) begin n_bad++; $display("FAIL halt0_halt got %b want 11", core_halt_o); end
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_bad++; $display("FAIL halt0_ready got %b want 0", cmd_ready_o); end
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) core_halted_i[0] = 1'b1;
      if (busy_o === 1'b1) busy_cnt++;
      if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL halt0_early_rsp cycle T+%0d got 1 want 0", c); end
      if (c < 4) tick();
    end
    n_cmp++; if (busy_cnt != 4) begin n_bad++; $display("FAIL halt0_busy_cycles got %0d want 4", busy_cnt); end
    tick(); // T+5
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL halt0_rsp got %b want 1", rsp_valid_o); end
    n_cmp++; if (rsp_status_o !== 2'b00) begin n_bad++; $display("FAIL halt0_status got %b want 00", rsp_status_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL halt0_busy_end got %b want 0", busy_o); end
    tick(); // T+6
    n_cmp++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL halt0_after got rsp=%b rdy=%b want rsp=0 rdy=1", rsp_valid_o, cmd_ready_o); end
    n_cmp++; if (core_halt_o[1] !== 1'b1) begin n_bad++; $display("FAIL halt0_other got %b want 1", core_halt_o[1]); end
  endtask

  task automatic test_resume_core1();
    send(32'h1);
    n_cmp++; if (core_halt_o !== 2'b01) begin n_bad++; $display("FAIL resume1_halt got %b want 01", core_halt_o); end
    core_halted_i[1] = 1'b0;
    tick(); // T+2
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00) begin n_bad++; $display("FAIL resume1_rsp got v=%b s=%b want v=1 s=00", rsp_valid_o, rsp_status_o); end
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_bad++; $display("FAIL resume1_ready_resp got %b want 0", cmd_ready_o); end
    tick(); // T+3
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL resume1_ready got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_badcmd();
    logic [31:0] bad [2];
    bad[0] = 32'h2; bad[1] = 32'h8;
    for (int b = 0; b < 2; b++) begin
      send(bad[b]);
      n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b01) begin n_bad++; $display("FAIL bad_%h_rsp got v=%b s=%b want v=1 s=01", bad[b], rsp_valid_o, rsp_status_o); end
      n_cmp++; if (core_halt_o !== 2'b01 || busy_o !== 1'b0) begin n_bad++; $display("FAIL bad_%h_state got halt=%b busy=%b want halt=01 busy=0", bad[b], core_halt_o, busy_o); end
      tick();
      n_cmp++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_status_o !== 2'b01) begin n_bad++; $display("FAIL bad_%h_after got rdy=%b v=%b s=%b want rdy=1 v=0 s=01", bad[b], cmd_ready_o, rsp_valid_o, rsp_status_o); end
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    send(32'h0);
    n_cmp++; if (core_halt_o !== 2'b11) begin n_bad++; $display("FAIL tmo_halt got %b want 11", core_halt_o); end
    for (int c = 1; c <= 8; c++) begin
      if (rsp_valid_o !== 1'b0) early++;
      tick();
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL tmo_early got %0d pulses want 0", early); end
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b10) begin n_bad++; $display("FAIL tmo_rsp got v=%b s=%b want v=1 s=10", rsp_valid_o, rsp_status_o); end
    n_cmp++; if (core_halt_o !== 2'b11) begin n_bad++; $display("FAIL tmo_keep got %b want 11", core_halt_o); end
    tick();
    n_cmp++; if (rsp_valid_o !== 1'b0 || rsp_status_o !== 2'b10) begin n_bad++; $display("FAIL tmo_hold got v=%b s=%b want v=0 s=10", rsp_valid_o, rsp_status_o); end
  endtask

  task automatic test_tie();
    send(32'h0);
    for (int c = 1; c < 8; c++) tick();
    core_halted_i[1] = 1'b1; // ack first seen on the last timeout cycle (T+8)
    n_cmp++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL tie_wait got v=%b busy=%b want v=0 busy=1", rsp_valid_o, busy_o); end
    tick();
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00) begin n_bad++; $display("FAIL tie_rsp got v=%b s=%b want v=1 s=00", rsp_valid_o, rsp_status_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    send(32'h1); // core 1 stays halted, so this waits
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b want 1", busy_o); end
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_bad++; $display("FAIL rmid_ready got %b want 0", cmd_ready_o); end
    n_cmp++; if (core_halt_o !== 2'b10 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_state got halt=%b busy=%b v=%b want halt=10 busy=0 v=0", core_halt_o, busy_o, rsp_valid_o); end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid_o !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rmid_no_rsp got %0d pulses want 0", pulses); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int rsps = 0;
    core_halted_i = 2'b10;
    cmd_valid_i = 1'b1;
    cmd_data_i  = 32'h7; // resume core 0, already running: immediate ack
    for (int c = 0; c < 9; c++) begin
      if (cmd_ready_o === 1'b1) accepts++;
      tick();
      if (rsp_valid_o === 1'b1) rsps++;
    end
    cmd_valid_i = 1'b0;
    n_cmp++; if (accepts != 3) begin n_bad++; $display("FAIL b2b_accepts got %0d want 3", accepts); end
    n_cmp++; if (rsps != 3) begin n_bad++; $display("FAIL b2b_rsps got %0d want 3", rsps); end
    n_cmp++; if (core_halt_o !== 2'b10) begin n_bad++; $display("FAIL b2b_halt got %b want 10", core_halt_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_halt_core0();
    test_resume_core1();
    test_badcmd();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
